serial_fetch_decode: RTL and testbench

- Fetch/decode stage directly downstream of the program counter in the serial R-type RISC-V core.
- Watches the PC value and fetches the 32-bit instruction word over a req/ack memory handshake.
- Latches the word into an instruction register and decodes the R-type fields.
- Then sequences the bit-serial datapath with an LSB-first bit index for XLEN cycles. A full pass (36 cycles at zero wait) fits well inside the PC's 99-cycle update period.

---
 rtl/serial_fetch_decode.sv | 220 ++++++++++++++++++++++
 tb/tb_serial_fetch_decode.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_fetch_decode.sv
// serial_fetch_decode
//   Fetch/decode stage behind the program counter of the serial R-type core.
//   When the PC changes, or on the first pass after reset, the block fetches
//   the instruction word over a req/ack handshake. It latches the word into
//   the instruction register and decodes the R-type fields. It then steps the
//   bit-serial datapath through XLEN LSB-first bit slots.
//
//   Optional build macro: FETCH_TIMEOUT_EN
//   When defined, a fetch watchdog is built. A fetch that gets no ack within
//   TIMEOUT cycles is abandoned, ir is loaded with a NOP, and illegal pulses.
//
// Ports
//   clk, reset      clock; synchronous active-high reset
//   i_pc_in         current PC (byte address)
//   o_mem_req       fetch request, held until acknowledged
//   o_mem_addr      word-aligned fetch address
//   i_mem_ack       memory acknowledge; i_mem_rdata is valid in the same cycle
//   i_mem_rdata     fetched instruction word
//   o_ir            instruction register
//   o_rd/o_rs1/o_rs2, o_funct3, o_funct7, o_is_rtype   decoded fields
//   o_bit_valid     serial slot active
//   o_bit_idx       current serial bit index
//   o_exec_done     one-cycle pulse at the end of a serial pass
//   o_illegal       one-cycle pulse on misaligned PC, non-R-type opcode or timeout
//   o_busy          high whenever the FSM is not idle
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | watching the PC for a change
// S_FETCH  | request outstanding, waiting for ack
// S_DECODE | fields decoded; branch to SHIFT or flag illegal opcode
// S_SHIFT  | stepping bit_idx 0..XLEN-1
// S_DONE   | exec_done pulse, then back to IDLE
module serial_fetch_decode #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_pc_in,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic [31:0] o_ir,
  output logic [4:0]  o_rd,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [2:0]  o_funct3,
  output logic [6:0]  o_funct7,
  output logic        o_is_rtype,
  output logic        o_bit_valid,
  output logic [5:0]  o_bit_idx,
  output logic        o_exec_done,
  output logic        o_illegal,
  output logic        o_busy
);

  localparam logic [6:0]  OPC_RTYPE = 7'b0110011;
  localparam logic [31:0] NOP_INSN  = 32'h0000_0013;
  localparam logic [5:0]  LAST_IDX  = 6'(XLEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic [31:0] r_pc_last;
  logic        r_primed;
  logic        r_mem_req;
  logic [31:0] r_mem_addr;
  logic [31:0] r_ir;
  logic [4:0]  r_rd;
  logic [4:0]  r_rs1;
  logic [4:0]  r_rs2;
  logic [2:0]  r_funct3;
  logic [6:0]  r_funct7;
  logic        r_is_rtype;
  logic [5:0]  r_bit_idx;
  logic        r_illegal;

  logic        w_trigger;
  logic        w_misaligned;
  logic        w_start_fetch;
  logic        w_ack;
  logic        w_last_bit;
  logic        w_timeout;

  // PC changes while busy are not latched; the comparison is simply repeated
  // once the FSM is back in IDLE, so only the newest PC gets fetched.
  assign w_trigger     = (r_state == S_IDLE) && (!r_primed || (i_pc_in != r_pc_last));
  assign w_misaligned  = (i_pc_in[1:0] != 2'b00);
  assign w_start_fetch = w_trigger && !w_misaligned;
  assign w_ack         = (r_state == S_FETCH) && r_mem_req && i_mem_ack;
  assign w_last_bit    = (r_bit_idx == LAST_IDX);

`ifdef FETCH_TIMEOUT_EN
  localparam int                WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(TIMEOUT - 1);

  // Down-counter loaded with the cycle count for the first FETCH cycle. The
  // watchdog fires in the FETCH cycle where it reads zero, so the request is
  // high for exactly TIMEOUT cycles. An ack in that same cycle still wins.
  logic [WAIT_W-1:0] r_wait_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait_cnt <= '0;
    end else if (w_start_fetch) begin
      r_wait_cnt <= WAIT_LOAD;
    end else if ((r_state == S_FETCH) && (r_wait_cnt != '0)) begin
      r_wait_cnt <= r_wait_cnt - 1'b1;
    end
  end

  assign w_timeout = (r_state == S_FETCH) && !i_mem_ack && (r_wait_cnt == '0);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_start_fetch) w_next_state = S_FETCH;
      S_FETCH: begin
        if (w_ack)          w_next_state = S_DECODE;
        else if (w_timeout) w_next_state = S_IDLE;
      end
      S_DECODE: w_next_state = r_is_rtype ? S_SHIFT : S_IDLE;
      S_SHIFT:  if (w_last_bit) w_next_state = S_DONE;
      S_DONE:   w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Fields are decoded straight from the returning word at the ack edge. This
  // makes them, and an illegal-opcode pulse, visible during the DECODE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc_last  <= '0;
      r_primed   <= 1'b0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_ir       <= '0;
      r_rd       <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_funct3   <= '0;
      r_funct7   <= '0;
      r_is_rtype <= 1'b0;
      r_bit_idx  <= '0;
      r_illegal  <= 1'b0;
    end else begin
      r_illegal <= 1'b0;

      if (w_trigger) begin
        r_pc_last <= i_pc_in;
        r_primed  <= 1'b1;
        if (w_misaligned) begin
          r_illegal <= 1'b1;
        end else begin
          r_mem_req  <= 1'b1;
          r_mem_addr <= {i_pc_in[31:2], 2'b00};
        end
      end

      if (w_ack) begin
        r_mem_req  <= 1'b0;
        r_ir       <= i_mem_rdata;
        r_rd       <= i_mem_rdata[11:7];
        r_funct3   <= i_mem_rdata[14:12];
        r_rs1      <= i_mem_rdata[19:15];
        r_rs2      <= i_mem_rdata[24:20];
        r_funct7   <= i_mem_rdata[31:25];
        r_is_rtype <= (i_mem_rdata[6:0] == OPC_RTYPE);
        r_illegal  <= (i_mem_rdata[6:0] != OPC_RTYPE);
      end

      if (w_timeout) begin
        r_mem_req <= 1'b0;
        r_ir      <= NOP_INSN;
        r_illegal <= 1'b1;
      end

      if (r_state == S_SHIFT) begin
        r_bit_idx <= w_last_bit ? 6'd0 : r_bit_idx + 6'd1;
      end
    end
  end

  assign o_mem_req   = r_mem_req;
  assign o_mem_addr  = r_mem_addr;
  assign o_ir        = r_ir;
  assign o_rd        = r_rd;
  assign o_rs1       = r_rs1;
  assign o_rs2       = r_rs2;
  assign o_funct3    = r_funct3;
  assign o_funct7    = r_funct7;
  assign o_is_rtype  = r_is_rtype;
  assign o_bit_valid = (r_state == S_SHIFT);
  assign o_bit_idx   = r_bit_idx;
  assign o_exec_done = (r_state == S_DONE);
  assign o_illegal   = r_illegal;
  assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_serial_fetch_decode.sv
// Bench for serial_fetch_decode. Each fetch is modelled as a timeline. The
// trigger cycle and the ack cycle fix every expected output as an interval of
// cycle numbers. All outputs are compared on every cycle, and directed literal
// checks pin the model itself.
module tb_serial_fetch_decode;
  localparam int XLEN    = 32;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_in = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] ir;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        is_rtype, bit_valid, exec_done, illegal, busy;
  logic [5:0]  bit_idx;

  always #5 clk = ~clk;

  serial_fetch_decode #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_pc_in    (pc_in),
    .o_mem_req  (mem_req),
    .o_mem_addr (mem_addr),
    .i_mem_ack  (mem_ack),
    .i_mem_rdata(mem_rdata),
    .o_ir       (ir),
    .o_rd       (rd),
    .o_rs1      (rs1),
    .o_rs2      (rs2),
    .o_funct3   (funct3),
    .o_funct7   (funct7),
    .o_is_rtype (is_rtype),
    .o_bit_valid(bit_valid),
    .o_bit_idx  (bit_idx),
    .o_exec_done(exec_done),
    .o_illegal  (illegal),
    .o_busy     (busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory behaviour for the next fetch: ack after next_wait cycles of request
  // (negative = never), returning next_rdata. stray = spurious ack while idle.
  int          next_wait = 0;
  logic [31:0] next_rdata = '0;
  logic        stray = 1'b0;

  // Timeline model
  int          cyc = 0;
  int          m_free = 0, m_a = -1, m_t = 0;
  int          req_lo = 0, req_hi = -1, bv_lo = 0, bv_hi = -1;
  int          busy_lo = 0, busy_hi = -1, done_c = -1, ill_c = -1;
  logic        m_primed = 1'b0;
  logic [31:0] m_pc_last = '0, m_ir = '0, m_dec = '0, m_addr = '0, op_rdata = '0;
  int          p_ir_c = -1, p_dec_c = -1, p_addr_c = -1;
  logic [31:0] p_ir = '0, p_dec = '0, p_addr = '0;
  logic        timed_out;

  // Observations used by the literal checks
  int          cnt_req = 0, cnt_ill = 0, cnt_bv = 0, cnt_done = 0, cnt_fetch = 0;
  int          done_cyc = -1;
  logic [31:0] last_req_addr = '0;
  logic        prev_req = 1'b0;

  function automatic logic inr(input int c, input int lo, input int hi);
    return (c >= lo) && (c <= hi);
  endfunction

  initial begin
    int c;
    forever begin
      @(negedge clk);
      c = cyc;
      if (c == p_ir_c)   m_ir   = p_ir;
      if (c == p_dec_c)  m_dec  = p_dec;
      if (c == p_addr_c) m_addr = p_addr;

      check("mem_req",   {31'd0, mem_req},   {31'd0, inr(c, req_lo, req_hi)});
      check("mem_addr",  mem_addr,           m_addr);
      check("busy",      {31'd0, busy},      {31'd0, inr(c, busy_lo, busy_hi)});
      check("bit_valid", {31'd0, bit_valid}, {31'd0, inr(c, bv_lo, bv_hi)});
      check("bit_idx",   {26'd0, bit_idx},   inr(c, bv_lo, bv_hi) ? 32'(c - bv_lo) : 32'd0);
      check("exec_done", {31'd0, exec_done}, {31'd0, (c == done_c)});
      check("illegal",   {31'd0, illegal},   {31'd0, (c == ill_c)});
      check("ir",        ir,                 m_ir);
      check("rd",        {27'd0, rd},        {27'd0, m_dec[11:7]});
      check("rs1",       {27'd0, rs1},       {27'd0, m_dec[19:15]});
      check("rs2",       {27'd0, rs2},       {27'd0, m_dec[24:20]});
      check("funct3",    {29'd0, funct3},    {29'd0, m_dec[14:12]});
      check("funct7",    {25'd0, funct7},    {25'd0, m_dec[31:25]});
      check("is_rtype",  {31'd0, is_rtype},  {31'd0, (m_dec[6:0] == 7'h33)});

      cnt_req  += int'(mem_req);
      cnt_ill  += int'(illegal);
      cnt_bv   += int'(bit_valid);
      if (exec_done) begin
        cnt_done++;
        done_cyc = c;
      end
      if (mem_req && !prev_req) begin
        cnt_fetch++;
        last_req_addr = mem_addr;
      end
      prev_req = mem_req;

      mem_ack   = (c == m_a) || (stray && (c >= m_free));
      mem_rdata = (c == m_a) ? op_rdata : (stray ? 32'hFFFF_FFFF : 32'd0);

      if (reset) begin
        req_hi = -1; bv_hi = -1; busy_hi = -1; done_c = -1; ill_c = -1; m_a = -1;
        m_free = c + 1; m_primed = 1'b0; m_pc_last = '0;
        p_ir_c = c + 1;   p_ir = '0;
        p_dec_c = c + 1;  p_dec = '0;
        p_addr_c = c + 1; p_addr = '0;
      end else if ((c >= m_free) && (!m_primed || (pc_in != m_pc_last))) begin
        m_t = c;
        m_primed = 1'b1;
        m_pc_last = pc_in;
        if (pc_in[1:0] != 2'b00) begin
          ill_c  = m_t + 1;
          m_free = m_t + 1;
        end else begin
          p_addr_c = m_t + 1;
          p_addr   = {pc_in[31:2], 2'b00};
          req_lo   = m_t + 1;
          busy_lo  = m_t + 1;
          op_rdata = next_rdata;
          timed_out = 1'b0;
`ifdef FETCH_TIMEOUT_EN
          timed_out = (next_wait < 0) || (next_wait >= TIMEOUT);
`endif
          if (timed_out) begin
            m_a = -1;
            req_hi  = m_t + TIMEOUT;
            busy_hi = m_t + TIMEOUT;
            ill_c   = m_t + TIMEOUT + 1;
            p_ir_c  = m_t + TIMEOUT + 1;
            p_ir    = 32'h0000_0013;
            m_free  = m_t + TIMEOUT + 1;
          end else begin
            m_a     = m_t + 1 + next_wait;
            req_hi  = m_a;
            p_ir_c  = m_a + 1; p_ir  = op_rdata;
            p_dec_c = m_a + 1; p_dec = op_rdata;
            if (op_rdata[6:0] == 7'h33) begin
              bv_lo   = m_a + 2;
              bv_hi   = m_a + 1 + XLEN;
              done_c  = m_a + 2 + XLEN;
              busy_hi = done_c;
              m_free  = done_c + 1;
            end else begin
              ill_c   = m_a + 1;
              busy_hi = m_a + 1;
              m_free  = m_a + 2;
            end
          end
        end
      end
      cyc++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr_counts();
    cnt_req = 0; cnt_ill = 0; cnt_bv = 0; cnt_done = 0; cnt_fetch = 0;
  endtask

  initial begin
    int r0;
    int d0;
    logic found;

    // Reset, PC 0, zero-wait add x3,x1,x2
    next_wait  = 0;
    next_rdata = 32'h0020_81B3;
    tick(3);
    reset = 1'b0;
    r0 = cyc;
    clr_counts();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_req",  {31'd0, mem_req}, 32'd0);
    check("rst_ir",   ir, 32'd0);
    tick(40);
    check("t1_latency",  32'(done_cyc - r0), 32'd35);
    check("t1_done_cnt", 32'(cnt_done), 32'd1);
    check("t1_bv_cnt",   32'(cnt_bv), 32'd32);
    check("t1_addr",     last_req_addr, 32'd0);
    check("t1_rd",       {27'd0, rd}, 32'd3);
    check("t1_rs1",      {27'd0, rs1}, 32'd1);
    check("t1_rs2",      {27'd0, rs2}, 32'd2);
    check("t1_rtype",    {31'd0, is_rtype}, 32'd1);

    // PC 4, three wait cycles, sub x5,x6,x7
    next_wait  = 3;
    next_rdata = 32'h4073_02B3;
    clr_counts();
    pc_in = 32'd4;
    tick(45);
    check("t2_req_cycles", 32'(cnt_req), 32'd4);
    check("t2_addr",       last_req_addr, 32'd4);
    check("t2_funct7",     {25'd0, funct7}, 32'h20);
    check("t2_rs2",        {27'd0, rs2}, 32'd7);
    check("t2_rs1",        {27'd0, rs1}, 32'd6);
    check("t2_rd",         {27'd0, rd}, 32'd5);
    check("t2_done_cnt",   32'(cnt_done), 32'd1);

    // Unchanged PC with spurious acks: nothing happens
    clr_counts();
    stray = 1'b1;
    tick(3);
    stray = 1'b0;
    tick(5);
    check("idle_req_cycles", 32'(cnt_req), 32'd0);
    check("idle_ir",         ir, 32'h4073_02B3);

    // PC 8, addi: illegal opcode
    next_wait  = 0;
    next_rdata = 32'h0050_0093;
    clr_counts();
    pc_in = 32'd8;
    tick(10);
    check("t3_ill_cnt", 32'(cnt_ill), 32'd1);
    check("t3_bv_cnt",  32'(cnt_bv), 32'd0);
    check("t3_ir",      ir, 32'h0050_0093);

    // Misaligned PC
    clr_counts();
    pc_in = 32'h6;
    tick(5);
    check("t4_ill_cnt", 32'(cnt_ill), 32'd1);
    check("t4_req_cnt", 32'(cnt_req), 32'd0);

    // PC 4 then 8, 12 during SHIFT; only 12 is fetched next; reset at bit 10
    next_wait  = 1;
    next_rdata = 32'h0020_81B3;
    pc_in = 32'd4;
    tick(10);
    next_wait  = 0;
    next_rdata = 32'h00C5_8533;
    pc_in = 32'd8;
    tick(5);
    pc_in = 32'd12;
    clr_counts();
    found = 1'b0;
    for (int i = 0; i < 120 && !found; i++) begin
      if ((cnt_fetch >= 1) && bit_valid && (bit_idx == 6'd10)) found = 1'b1;
      else tick(1);
    end
    check("t5_reached_bit10", {31'd0, found}, 32'd1);
    check("t5_fetch_cnt",     32'(cnt_fetch), 32'd1);
    check("t5_addr",          last_req_addr, 32'd12);
    check("t5_rd",            {27'd0, rd}, 32'd10);
    d0 = cnt_done;
    reset = 1'b1;
    tick(1);
    check("t5_bv_after_rst",  {31'd0, bit_valid}, 32'd0);
    check("t5_req_after_rst", {31'd0, mem_req}, 32'd0);
    reset = 1'b0;
    tick(3);
    check("t5_no_done", 32'(cnt_done), 32'(d0));
    tick(40);

`ifdef FETCH_TIMEOUT_EN
    // Memory never answers
    next_wait = -1;
    clr_counts();
    pc_in = 32'd16;
    tick(25);
    check("t6_req_cycles", 32'(cnt_req), 32'd16);
    check("t6_ir",         ir, 32'h0000_0013);
    check("t6_ill_cnt",    32'(cnt_ill), 32'd1);
    check("t6_bv_cnt",     32'(cnt_bv), 32'd0);
    stray = 1'b1;
    tick(2);
    stray = 1'b0;
    tick(3);
    check("t6_late_ack_ir", ir, 32'h0000_0013);
`endif

    clr_counts();
    tick(10);
    check("final_idle_req", 32'(cnt_req), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
